// File: rtl/imem_fetch_ctrl.sv
// Instruction-memory sequencer: clears the memory, loads a program image,
// then fetches instruction/PC pairs for decode until a redirect or halt.
module imem_fetch_ctrl #(
  parameter int          DEPTH    = 64,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_valid,
  input  logic [31:0] load_data,
  input  logic        load_last,
  output logic        load_ready,
  output logic        mem_we,
  output logic [31:0] mem_waddr,
  output logic [31:0] mem_wdata,
  output logic [31:0] mem_raddr,
  input  logic [31:0] mem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        busy,
  output logic        err_misalign,
  output logic [1:0]  dbg_state
);

  localparam int          CW       = $clog2(DEPTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEPTH - 1);
  localparam logic [31:0] PC_LIMIT = 32'(DEPTH * 4);
  localparam logic [31:0] PC_LAST  = 32'((DEPTH - 1) * 4);

  typedef enum logic [1:0] {S_CLEAR, S_LOAD, S_RUN, S_HALT} state_t;

  state_t        r_state, w_state_n;
  logic [CW-1:0] r_cnt, w_cnt_n;
  logic [31:0]   r_pc, w_pc_n;
  logic          r_err, w_err_n;
  logic          w_bad_align, w_out_of_range;

  // Handshakes: load accepts when load_valid & load_ready; decode takes an
  // instruction when if_valid & if_ready. Both complete on the rising edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_CLEAR;
      r_cnt   <= '0;
      r_pc    <= RESET_PC;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_pc    <= w_pc_n;
      r_err   <= w_err_n;
    end
  end

  always_comb begin
    w_state_n      = r_state;
    w_cnt_n        = r_cnt;
    w_pc_n         = r_pc;
    w_err_n        = r_err;
    w_bad_align    = (redirect_pc[1:0] != 2'b00);
    w_out_of_range = (redirect_pc >= PC_LIMIT);

    load_ready = 1'b0;
    mem_we     = 1'b0;
    mem_waddr  = {{(30-CW){1'b0}}, r_cnt, 2'b00};
    mem_wdata  = 32'h0;
    mem_raddr  = r_pc;
    if_valid   = 1'b0;
    if_instr   = mem_rdata;
    if_pc      = r_pc;
    busy       = 1'b0;

    case (r_state)
      S_CLEAR: begin
        mem_we  = 1'b1;
        busy    = 1'b1;
        w_cnt_n = r_cnt + CW'(1);
        if (r_cnt == CNT_LAST) begin
          w_cnt_n   = '0;
          w_state_n = S_LOAD;
        end
      end
      S_LOAD: begin
        load_ready = 1'b1;
        busy       = 1'b1;
        mem_we     = load_valid;
        mem_wdata  = load_data;
        if (load_valid) begin
          w_cnt_n = r_cnt + CW'(1);
          // The memory is full after the last index, so loading ends there too.
          if (load_last || (r_cnt == CNT_LAST)) begin
            w_cnt_n   = '0;
            w_state_n = S_RUN;
            w_pc_n    = RESET_PC;
          end
        end
      end
      S_RUN: begin
        if_valid = !redirect_valid;
        if (redirect_valid) begin
          if (w_bad_align) begin
            w_err_n   = 1'b1;
            w_state_n = S_HALT;
          end else if (w_out_of_range) begin
            w_state_n = S_HALT;
          end else begin
            w_pc_n = redirect_pc;
          end
        end else if (if_ready) begin
          if (r_pc == PC_LAST) w_state_n = S_HALT;
          else                 w_pc_n    = r_pc + 32'd4;
        end
      end
      default: begin
        if (redirect_valid) begin
          if (w_bad_align) begin
            w_err_n = 1'b1;
          end else if (!w_out_of_range) begin
            w_pc_n    = redirect_pc;
            w_state_n = S_RUN;
          end
        end
      end
    endcase

    // Reset forces the interface quiet regardless of the registered state.
    if (rst) begin
      mem_we     = 1'b0;
      load_ready = 1'b0;
      if_valid   = 1'b0;
      busy       = 1'b1;
    end
  end

  assign err_misalign = r_err;
  assign dbg_state    = r_state;

endmodule
